// File: rtl/aref_ctrl.sv
// rtl/aref_ctrl.sv - auto-refresh engine: interval ticking, owed-refresh count, PREA/REF issue (optional AREF_BURST_EN)
module aref_ctrl #(
  parameter int INTERVAL_W  = 28,
  parameter int MAX_PENDING = 8,
  parameter int TRP_CYCLES  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  aref_set_interval,
  input  logic [INTERVAL_W-1:0] aref_interval,
  input  logic                  aref_set_trfc,
  input  logic [INTERVAL_W-1:0] aref_trfc,
  output logic                  aref_req,
  input  logic                  aref_gnt,
  output logic                  instr_en,
  output logic [31:0]           instr,
  input  logic                  instr_ack,
  output logic                  aref_busy,
  output logic [3:0]            pending_cnt,
  output logic                  overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_PREA,
    S_WAIT_RP,
    S_REF,
    S_WAIT_RFC
  } state_e;

  localparam logic [3:0]            MAX_P    = 4'(MAX_PENDING);
  localparam logic [INTERVAL_W-1:0] ONE      = INTERVAL_W'(1);
  localparam logic [INTERVAL_W-1:0] TRP_LAST = INTERVAL_W'(TRP_CYCLES - 1);

  // DDR_INSTR layout: [31:28] opcode, [27] CKE, [26] CS_n, [25] RAS_n,
  // [24] CAS_n, [23] WE_n, [17:15] bank, [14:0] address (A10 = bit 10)
  function automatic logic [31:0] ddr_word(input logic ras_n, input logic cas_n,
                                           input logic we_n, input logic a10);
    logic [31:0] w;
    w        = '0;
    w[31:28] = 4'b1000;
    w[27]    = 1'b1;
    w[26]    = 1'b0;
    w[25]    = ras_n;
    w[24]    = cas_n;
    w[23]    = we_n;
    w[10]    = a10;
    return w;
  endfunction

  localparam logic [31:0] PREA_WORD = ddr_word(1'b0, 1'b1, 1'b0, 1'b1);
  localparam logic [31:0] REF_WORD  = ddr_word(1'b0, 1'b0, 1'b1, 1'b0);

  state_e                  state_q;
  logic [INTERVAL_W-1:0]   interval_q;
  logic [INTERVAL_W-1:0]   trfc_q;
  logic [INTERVAL_W-1:0]   tick_cnt_q;
  logic [INTERVAL_W-1:0]   wait_q;
  logic [INTERVAL_W-1:0]   trfc_lat_q;
  logic [3:0]              pending_q, pending_d;
  logic                    overflow_q, overflow_d;
  logic                    req_q;
  logic                    en_q;
  logic [31:0]             instr_q;
  logic                    tick;
  logic                    ref_done;

  // A reload of the interval restarts the count, so it swallows a coinciding wrap
  assign tick     = !aref_set_interval && (interval_q != '0) &&
                    (tick_cnt_q == interval_q - ONE);
  assign ref_done = (state_q == S_REF) && instr_ack;

  // Configuration registers and the free-running interval counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      interval_q <= '0;
      trfc_q     <= '0;
      tick_cnt_q <= '0;
    end else begin
      if (aref_set_trfc) begin
        trfc_q <= aref_trfc;
      end
      if (aref_set_interval) begin
        interval_q <= aref_interval;
        tick_cnt_q <= '0;
      end else if (interval_q != '0) begin
        tick_cnt_q <= tick ? '0 : tick_cnt_q + ONE;
      end
    end
  end

  // Owed-refresh bookkeeping: tick adds, REF ack removes, both together cancel
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (tick && !ref_done) begin
      if (pending_q == MAX_P) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + 4'd1;
      end
    end else if (ref_done && !tick && (pending_q != 4'd0)) begin
      pending_d = pending_q - 4'd1;
    end
  end

  // Registered owed-refresh count and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  // Refresh sequencer with registered request/instruction outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      en_q       <= 1'b0;
      instr_q    <= '0;
      wait_q     <= '0;
      trfc_lat_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pending_q != 4'd0) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
          end
        end
        S_REQ: begin
          if (aref_gnt) begin
            state_q <= S_PREA;
            en_q    <= 1'b1;
            instr_q <= PREA_WORD;
          end
        end
        S_PREA: begin
          // Losing the slot before the precharge is taken means nothing was issued
          if (!aref_gnt) begin
            state_q <= S_REQ;
            en_q    <= 1'b0;
            instr_q <= '0;
          end else if (instr_ack) begin
            state_q <= S_WAIT_RP;
            en_q    <= 1'b0;
            instr_q <= '0;
            wait_q  <= '0;
          end
        end
        S_WAIT_RP: begin
          if (wait_q == TRP_LAST) begin
            state_q <= S_REF;
            en_q    <= 1'b1;
            instr_q <= REF_WORD;
          end else begin
            wait_q <= wait_q + ONE;
          end
        end
        S_REF: begin
          if (instr_ack) begin
            state_q    <= S_WAIT_RFC;
            en_q       <= 1'b0;
            instr_q    <= '0;
            wait_q     <= '0;
            // tRFC is sampled here so a mid-wait reprogram only affects later refreshes
            trfc_lat_q <= (trfc_q == '0) ? ONE : trfc_q;
          end
        end
        S_WAIT_RFC: begin
          if (wait_q == trfc_lat_q - ONE) begin
`ifdef AREF_BURST_EN
            // Banks are still closed, so further owed refreshes skip the precharge
            if ((pending_q != 4'd0) && aref_gnt) begin
              state_q <= S_REF;
              en_q    <= 1'b1;
              instr_q <= REF_WORD;
            end else begin
              state_q <= S_IDLE;
              req_q   <= 1'b0;
            end
`else
            state_q <= S_IDLE;
            req_q   <= 1'b0;
`endif
          end else begin
            wait_q <= wait_q + ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          en_q    <= 1'b0;
          instr_q <= '0;
        end
      endcase
    end
  end

  // The precharge offer is withdrawn in the same cycle the grant disappears
  assign instr_en    = en_q && (aref_gnt || (state_q != S_PREA));
  assign instr       = instr_q;
  assign aref_req    = req_q;
  assign aref_busy   = (state_q != S_IDLE);
  assign pending_cnt = pending_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_aref_ctrl.sv
// tb/tb_aref_ctrl.sv - self-checking bench for aref_ctrl
module tb_aref_ctrl;

  localparam int TRP = 4;
  localparam int MAXP = 8;
  localparam logic [31:0] PREA_W = 32'h8900_0400;
  localparam logic [31:0] REF_W  = 32'h8880_0000;

  typedef struct {
    int trfc;
    int dp;
    int dr;
    int exp_busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aref_set_interval;
  logic [27:0] aref_interval;
  logic        aref_set_trfc;
  logic [27:0] aref_trfc;
  logic        aref_req;
  logic        aref_gnt;
  logic        instr_en;
  logic [31:0] instr;
  logic        instr_ack;
  logic        aref_busy;
  logic [3:0]  pending_cnt;
  logic        overflow;

  logic gnt_tie, gnt_force, ack_mode;
  int   dp, dr, en_age;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  // monitor state
  logic mon_on;
  logic req_prev, en_prev, ack_prev;
  logic [31:0] instr_prev;
  int busy_cnt, req_rises, n_prea, n_ref, n_other;
  int req_rise_cyc, prea_rise_cyc, prea_ack_cyc, ref_rise_cyc;

  vec_t vecs[4];

  aref_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .aref_set_interval (aref_set_interval),
    .aref_interval     (aref_interval),
    .aref_set_trfc     (aref_set_trfc),
    .aref_trfc         (aref_trfc),
    .aref_req          (aref_req),
    .aref_gnt          (aref_gnt),
    .instr_en          (instr_en),
    .instr             (instr),
    .instr_ack         (instr_ack),
    .aref_busy         (aref_busy),
    .pending_cnt       (pending_cnt),
    .overflow          (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign aref_gnt  = gnt_tie ? aref_req : gnt_force;
  assign instr_ack = ack_mode && instr_en && (en_age == ((instr == PREA_W) ? dp : dr));

  always @(posedge clk) begin
    if (instr_en && !instr_ack) en_age <= en_age + 1;
    else en_age <= 0;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (aref_busy) busy_cnt++;
      if (aref_req && !req_prev) begin
        req_rises++;
        req_rise_cyc = cyc;
      end
      if (instr_en && !en_prev) begin
        if (instr == PREA_W) prea_rise_cyc = cyc;
        if (instr == REF_W) ref_rise_cyc = cyc;
      end
      if (instr_en && en_prev && !ack_prev) chk("instr_stable", int'(instr), int'(instr_prev));
      if (instr_en && instr_ack) begin
        if (instr == PREA_W) begin
          n_prea++;
          prea_ack_cyc = cyc;
        end else if (instr == REF_W) begin
          n_ref++;
        end else begin
          n_other++;
        end
      end
      req_prev   = aref_req;
      en_prev    = instr_en;
      ack_prev   = instr_ack;
      instr_prev = instr;
    end
  end

  task automatic tick1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon;
    busy_cnt = 0; req_rises = 0; n_prea = 0; n_ref = 0; n_other = 0;
    req_rise_cyc = 0; prea_rise_cyc = 0; prea_ack_cyc = 0; ref_rise_cyc = 0;
    req_prev = aref_req; en_prev = instr_en; ack_prev = instr_ack; instr_prev = instr;
  endtask

  task automatic do_reset;
    mon_on = 1'b0;
    rst_n = 1'b0;
    aref_set_interval = 1'b0; aref_interval = '0;
    aref_set_trfc = 1'b0; aref_trfc = '0;
    gnt_tie = 1'b0; gnt_force = 1'b0; ack_mode = 1'b0; dp = 0; dr = 0;
    tick1;
    tick1;
    rst_n = 1'b1;
    tick1;
  endtask

  task automatic set_interval(input int v);
    aref_interval = 28'(v);
    aref_set_interval = 1'b1;
    tick1;
    aref_set_interval = 1'b0;
  endtask

  task automatic set_trfc(input int v);
    aref_trfc = 28'(v);
    aref_set_trfc = 1'b1;
    tick1;
    aref_set_trfc = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, int'(aref_req), 0);
    chk({tag, "_en"}, int'(instr_en), 0);
    chk({tag, "_instr"}, int'(instr), 0);
    chk({tag, "_busy"}, int'(aref_busy), 0);
    chk({tag, "_pend"}, int'(pending_cnt), 0);
    chk({tag, "_ovf"}, int'(overflow), 0);
  endtask

  task automatic single_refresh(input vec_t v);
    int set_cyc, n;
    do_reset();
    gnt_tie = 1'b1; ack_mode = 1'b1; dp = v.dp; dr = v.dr;
    set_trfc(v.trfc);
    clear_mon();
    mon_on = 1'b1;
    set_interval(100);
    set_cyc = cyc;
    n = 0;
    while (pending_cnt == 0 && n < 300) begin tick1; n++; end
    chk("tick_latency", cyc - set_cyc, 100);
    chk("req_before", int'(aref_req), 0);
    tick1;
    chk("req_latency", int'(aref_req), 1);
    n = 0;
    while (aref_busy && n < 400) begin tick1; n++; end
    chk("busy_timeout", int'(n < 400), 1);
    chk("n_prea", n_prea, 1);
    chk("n_ref", n_ref, 1);
    chk("n_other", n_other, 0);
    chk("gnt_to_en", prea_rise_cyc - req_rise_cyc, 1);
    chk("wait_rp", ref_rise_cyc - prea_ack_cyc - 1, TRP);
    chk("busy_span", busy_cnt, v.exp_busy);
    chk("pend_after", int'(pending_cnt), 0);
    set_interval(0);
  endtask

  initial begin
    int n, k1, k2, iv1, iv2, base, tot, e;
    vec_t v;

    do_reset();
    chk_all_zero("reset");

    // single-refresh vectors: busy = REQ + PREA(1+dp) + tRP + REF(1+dr) + max(trfc,1)
    vecs[0] = '{trfc: 20, dp: 0, dr: 0, exp_busy: 27};
    vecs[1] = '{trfc: 0,  dp: 0, dr: 0, exp_busy: 8};
    vecs[2] = '{trfc: 1,  dp: 2, dr: 3, exp_busy: 13};
    vecs[3] = '{trfc: 5,  dp: 7, dr: 0, exp_busy: 19};
    for (int i = 0; i < 7; i++) begin
      if (i < 4) begin
        v = vecs[i];
      end else begin
        v.trfc = $urandom_range(0, 30);
        v.dp   = $urandom_range(0, 6);
        v.dr   = $urandom_range(0, 6);
        v.exp_busy = 1 + (1 + v.dp) + TRP + (1 + v.dr) + ((v.trfc == 0) ? 1 : v.trfc);
      end
      single_refresh(v);
    end

    // saturation with the slot never granted
    do_reset();
    set_interval(10);
    for (int k = 1; k <= 200; k++) begin
      tick1;
      if (k == 79) begin chk("sat79_p", int'(pending_cnt), 7); chk("sat79_o", int'(overflow), 0); end
      if (k == 80) begin chk("sat80_p", int'(pending_cnt), 8); chk("sat80_o", int'(overflow), 0); end
      if (k == 89) begin chk("sat89_o", int'(overflow), 0); end
      if (k == 90) begin chk("sat90_p", int'(pending_cnt), 8); chk("sat90_o", int'(overflow), 1); end
    end
    chk("sat_end_p", int'(pending_cnt), 8);
    chk("sat_end_o", int'(overflow), 1);
    chk("sat_req", int'(aref_req), 1);

    // random intervals: owed count is floor(elapsed/interval) per segment, clipped at MAX
    for (int t = 0; t < 6; t++) begin
      do_reset();
      iv1 = $urandom_range(1, 12); k1 = $urandom_range(5, 60);
      iv2 = $urandom_range(1, 12); k2 = $urandom_range(5, 60);
      set_interval(iv1);
      for (int k = 1; k <= k1; k++) begin
        tick1;
        tot = k / iv1;
        e = (tot > MAXP) ? MAXP : tot;
        chk("rnd_pend1", int'(pending_cnt), e);
        chk("rnd_ovf1", int'(overflow), int'(tot > MAXP));
      end
      base = k1 / iv1;
      set_interval(iv2);
      for (int k = 1; k <= k2; k++) begin
        tick1;
        tot = base + k / iv2;
        e = (tot > MAXP) ? MAXP : tot;
        chk("rnd_pend2", int'(pending_cnt), e);
        chk("rnd_ovf2", int'(overflow), int'(tot > MAXP));
      end
    end

    // grant withdrawn during PREA, then asynchronous reset mid-PREA
    do_reset();
    set_trfc(2);
    set_interval(10);
    n = 0;
    while (pending_cnt == 0 && n < 50) begin tick1; n++; end
    set_interval(0);
    chk("gl_req", int'(aref_req), 1);
    gnt_force = 1'b1;
    tick1;
    chk("gl_en", int'(instr_en), 1);
    chk("gl_word", int'(instr), int'(PREA_W));
    tick1;
    tick1;
    gnt_force = 1'b0;
    #1;
    chk("gl_en_drop", int'(instr_en), 0);
    tick1;
    chk("gl_busy", int'(aref_busy), 1);
    chk("gl_req2", int'(aref_req), 1);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      tick1;
      if (instr_en) n++;
    end
    chk("gl_no_ref", n, 0);
    chk("gl_pend", int'(pending_cnt), 1);
    gnt_force = 1'b1;
    tick1;
    chk("gl_regrant", int'(instr_en), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    tick1;
    rst_n = 1'b1;
    gnt_force = 1'b0;

    // three owed refreshes under one held grant
    do_reset();
    ack_mode = 1'b1;
    set_trfc(3);
    set_interval(10);
    n = 0;
    while (pending_cnt != 3 && n < 100) begin tick1; n++; end
    set_interval(0);
    chk("burst_pend", int'(pending_cnt), 3);
    clear_mon();
    mon_on = 1'b1;
    gnt_force = 1'b1;
    n = 0;
    while ((pending_cnt != 0 || aref_busy) && n < 400) begin tick1; n++; end
    chk("burst_timeout", int'(n < 400), 1);
    chk("burst_ref", n_ref, 3);
`ifdef AREF_BURST_EN
    chk("burst_prea", n_prea, 1);
    chk("burst_rises", req_rises, 0);
`else
    chk("burst_prea", n_prea, 3);
    chk("burst_rises", req_rises, 2);
`endif
    chk("burst_other", n_other, 0);
    chk("burst_ovf", int'(overflow), 0);
    mon_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
